// File: rtl/flash_prog_seq.sv
// flash_prog_seq: command sequencer in front of a word-oriented flash driver.
// It runs read / erase / program / verify commands over a word range and
// issues one driver access at a time. Program and verify data come from an
// internal write FIFO that commands do not flush.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   cmd_*_i / cmd_ready_o    command handshake (op, base word address, length)
//   wr_*                     write-data stream into the FIFO
//   rd_*                     read-back stream
//   drv_*                    driver access: address, data, one enable, done
//   busy_o, done_o           activity flag and one-cycle completion pulse
//   err_o, err_addr_o        error flag and the first offending address
//   mismatch_cnt_o           compare failures of the last verify command
module flash_prog_seq #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int BLOCK_WORDS = 65536,
  parameter int TIMEOUT     = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [ADDR_W-1:0] drv_addr_o,
  output logic [DATA_W-1:0] drv_wdata_o,
  input  logic [DATA_W-1:0] drv_rdata_i,
  output logic              drv_rd_en_o,
  output logic              drv_er_en_o,
  output logic              drv_wr_en_o,
  input  logic              drv_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [15:0]       mismatch_cnt_o
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BSH = $clog2(BLOCK_WORDS);
  localparam logic [1:0] OP_RD = 2'd0, OP_ER = 2'd1, OP_PG = 2'd2, OP_VF = 2'd3;

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, ISSUE, WAIT, EMIT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, err_addr_q, err_addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       mcnt_q, mcnt_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;

  // write FIFO; extra pointer bit distinguishes full from empty
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]       wp_q, rp_q;
  logic              full, empty, push, pop;

  assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign empty = (wp_q == rp_q);
  assign push  = wr_valid_i && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[PW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // range arithmetic for CHECK: cnt_q still holds the requested length there
  logic [ADDR_W+1:0] end_excl;
  logic [ADDR_W-1:0] last_a, blk_span;
  logic              ovf;
  assign end_excl = {2'b00, base_q} + {1'b0, cnt_q};
  assign ovf      = end_excl > {2'b01, {ADDR_W{1'b0}}};
  assign last_a   = end_excl[ADDR_W-1:0] - ADDR_W'(1);
  assign blk_span = (last_a >> BSH) - (base_q >> BSH);

  logic last_acc;
  assign last_acc = (cnt_q == (ADDR_W+1)'(1));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    base_d     = base_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    mcnt_d     = mcnt_q;
    wcnt_d     = wcnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid_i) begin
        op_d       = cmd_op_i;
        base_d     = cmd_base_i;
        addr_d     = cmd_base_i;
        cnt_d      = cmd_len_i;
        err_d      = 1'b0;
        err_addr_d = '0;
        mcnt_d     = '0;
        state_d    = CHECK;
      end
      CHECK: begin
        if (cnt_q == '0) state_d = FINISH;
        else if (ovf) begin
          err_d      = 1'b1;
          err_addr_d = base_q;
          state_d    = FINISH;
        end else if (op_q == OP_ER) begin
          // erase walks whole blocks: align down, count blocks touched
          addr_d  = base_q & ~(ADDR_W'(BLOCK_WORDS - 1));
          cnt_d   = {1'b0, blk_span} + (ADDR_W+1)'(1);
          state_d = ISSUE;
        end else if (op_q == OP_RD) state_d = ISSUE;
        else state_d = FETCH;
      end
      // also serves as the idle gap between erase/program/verify accesses
      FETCH: begin
        if (op_q == OP_ER) state_d = ISSUE;
        else if (!empty) begin
          pop     = 1'b1;
          wdata_d = mem_q[rp_q[PW-1:0]];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (drv_done_i) begin
          if (op_q == OP_RD) begin
            rdata_d = drv_rdata_i;
            state_d = EMIT;
          end else begin
            if (op_q == OP_VF && drv_rdata_i != wdata_q) begin
              if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
              if (!err_q) begin
                err_d      = 1'b1;
                err_addr_d = addr_q;
              end
            end
            addr_d  = (op_q == OP_ER) ? addr_q + ADDR_W'(BLOCK_WORDS) : addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - (ADDR_W+1)'(1);
            state_d = last_acc ? FINISH : FETCH;
          end
        end else if (wcnt_q == TW'(TIMEOUT)) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = FINISH;
        end else wcnt_d = wcnt_q + TW'(1);
      end
      EMIT: if (rd_ready_i) begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - (ADDR_W+1)'(1);
        state_d = last_acc ? FINISH : ISSUE;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      base_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      mcnt_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      mcnt_q     <= mcnt_d;
      wcnt_q     <= wcnt_d;
    end
  end

  logic acc;
  assign acc            = (state_q == ISSUE) || (state_q == WAIT);
  assign drv_rd_en_o    = acc && (op_q == OP_RD || op_q == OP_VF);
  assign drv_er_en_o    = acc && (op_q == OP_ER);
  assign drv_wr_en_o    = acc && (op_q == OP_PG);
  assign drv_addr_o     = addr_q;
  assign drv_wdata_o    = wdata_q;
  assign rd_data_o      = rdata_q;
  assign rd_valid_o     = (state_q == EMIT);
  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == FINISH);
  assign err_o          = err_q;
  assign err_addr_o     = err_addr_q;
  assign mismatch_cnt_o = mcnt_q;
  assign wr_ready_o     = !full;
endmodule

// File: tb/tb_flash_prog_seq.sv
// Bench for flash_prog_seq: a behavioural driver/flash model, a FIFO model,
// and scoreboards of expected driver accesses and read-back words.
module tb_flash_prog_seq;
  localparam int AW = 22, DW = 16, TO = 16, DLY = 5;
  localparam logic [1:0] RD = 2'd0, ER = 2'd1, PG = 2'd2, VF = 2'd3;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] wr_data = '0, rd_data, drv_wdata, drv_rdata;
  logic          wr_valid = 1'b0, wr_ready, rd_valid, rdy = 1'b1;
  logic [AW-1:0] drv_addr, err_addr;
  logic          rd_en, er_en, wr_en, drv_done, busy, done, err;
  logic [15:0]   mcnt;

  flash_prog_seq #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .BLOCK_WORDS(65536), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rdy),
    .drv_addr_o(drv_addr), .drv_wdata_o(drv_wdata), .drv_rdata_i(drv_rdata),
    .drv_rd_en_o(rd_en), .drv_er_en_o(er_en), .drv_wr_en_o(wr_en), .drv_done_i(drv_done),
    .busy_o(busy), .done_o(done), .err_o(err), .err_addr_o(err_addr), .mismatch_cnt_o(mcnt));

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // access scoreboard; en is {rd,er,wr}
  typedef struct { logic [2:0] en; logic [AW-1:0] addr; logic [DW-1:0] data; bit chkd; } acc_t;
  acc_t          acc_q[$];
  logic [DW-1:0] rd_q[$], fifo_m[$];
  logic [DW-1:0] flash [int];
  bit            exp_err;
  logic [AW-1:0] exp_ea;
  int            exp_mm, done_cnt, last_run;
  bit            hang = 1'b0;

  function automatic logic [DW-1:0] rdf(input int a);
    return flash.exists(a) ? flash[a] : '0;
  endfunction

  // driver: done DLY cycles into an access, never while hung
  initial begin
    int dcnt = 0;
    drv_done = 1'b0; drv_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!(rd_en | er_en | wr_en) || hang) begin
        drv_done = 1'b0; dcnt = 0;
      end else begin
        dcnt++;
        if (dcnt == DLY) begin
          drv_done = 1'b1;
          drv_rdata = rdf(int'(drv_addr));
        end
      end
    end
  end

  // monitor: access start/hold, done pulses, read-back handshakes
  initial begin
    logic [2:0] en, en_prev;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    int run;
    bit stab;
    acc_t a;
    en_prev = '0; run = 0; stab = 1'b1; cap_a = '0; cap_d = '0;
    forever begin
      @(negedge clk);
      en = {rd_en, er_en, wr_en};
      if (en != 0 && en_prev == 0) begin
        chk("onehot", $countones(en), 1);
        chk("acc_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          chk("acc_en", en, a.en);
          chk("acc_addr", drv_addr, a.addr);
          if (a.chkd) chk("acc_data", drv_wdata, a.data);
        end
        cap_a = drv_addr; cap_d = drv_wdata; run = 0; stab = 1'b1;
      end
      if (en != 0) begin
        run++;
        if (drv_addr !== cap_a || drv_wdata !== cap_d || (en_prev != 0 && en != en_prev)) stab = 1'b0;
      end
      if (en == 0 && en_prev != 0) begin
        last_run = run;
        chk("acc_stable", stab, 1);
      end
      if (done) done_cnt++;
      if (rd_valid && rdy) begin
        chk("rd_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) chk("rd_data", rd_data, rd_q.pop_front());
      end
      en_prev = en;
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
    end
    chk("wr_ready", ok, 1);
    wr_data = w; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    fifo_m.push_back(w);
  endtask

  // builds the expected outcome from the models, then hands the command over
  task automatic issue(input logic [1:0] op, input int base, input int len);
    longint e = longint'(base) + longint'(len);
    bit ok = 1'b0;
    acc_t a;
    logic [DW-1:0] w;
    exp_err = 1'b0; exp_ea = '0; exp_mm = 0;
    if (len != 0 && e > (longint'(1) << AW)) begin
      exp_err = 1'b1; exp_ea = base[AW-1:0];
    end else if (len != 0) begin
      if (op == ER) begin
        for (longint b = base >> 16; b <= (e - 1) >> 16; b++) begin
          a.en = 3'b010; a.addr = AW'(b << 16); a.data = '0; a.chkd = 1'b0;
          acc_q.push_back(a);
        end
      end else begin
        for (int i = 0; i < len; i++) begin
          a.addr = AW'(base + i); a.data = '0; a.chkd = 1'b0;
          a.en = (op == PG) ? 3'b001 : 3'b100;
          if (op != RD) w = fifo_m.pop_front();
          if (op == PG) begin a.data = w; a.chkd = 1'b1; end
          if (op == VF && rdf(base + i) !== w) begin
            if (exp_mm == 0) begin exp_err = 1'b1; exp_ea = AW'(base + i); end
            exp_mm++;
          end
          if (op == RD) rd_q.push_back(rdf(base + i));
          acc_q.push_back(a);
        end
      end
    end
    done_cnt = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    chk("cmd_ready", ok, 1);
    cmd_op = op; cmd_base = base[AW-1:0]; cmd_len = len[AW:0]; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts cycles from the accept edge; exp_lat<=0 skips that check
  task automatic finish(input int exp_lat);
    int lat = 1;
    bit seen = done;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      seen = done;
    end
    chk("done_seen", seen, 1);
    if (exp_lat > 0) chk("done_lat", lat, exp_lat);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("err", err, exp_err);
    chk("err_addr", err_addr, exp_ea);
    chk("mismatch_cnt", mcnt, exp_mm);
    chk("acc_left", acc_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] held;
    bit ok, hold_ok;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_addr, mcnt}, 0);
    chk("rst_drv", {rd_en, er_en, wr_en, drv_addr, drv_wdata}, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b1;
    flash[32'h10] = 16'h00A1; flash[32'h11] = 16'h0000; flash[32'h12] = 16'h00C3;

    // program three preloaded words
    push_word(16'h00A1); push_word(16'h00B2); push_word(16'h00C3);
    issue(PG, 32'h10, 3); finish(0);
    // verify with one bad word in the middle
    push_word(16'h00A1); push_word(16'h00B2); push_word(16'h00C3);
    issue(VF, 32'h10, 3); finish(0);
    // erase straddling a block boundary
    issue(ER, 32'hFFFF, 2); finish(0);

    // read with the consumer stalled
    rdy = 1'b0;
    issue(RD, 32'h10, 2);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rd_valid) ok = 1'b1;
    end
    chk("rd_valid_seen", ok, 1);
    held = rd_data; hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rd_valid || rd_data !== held || (rd_en | er_en | wr_en)) hold_ok = 1'b0;
    end
    chk("rd_hold", hold_ok, 1);
    chk("rd_hold_noacc", acc_q.size(), 1);
    @(posedge clk); #1 rdy = 1'b1;
    finish(0);

    // zero length and out of range: straight to done, no access
    issue(RD, 32'h5, 0); finish(2);
    issue(PG, 32'h3FFFFF, 2); finish(2);

    // leftover FIFO words carry over between commands
    push_word(16'h00D4); push_word(16'h00E5);
    issue(PG, 32'h40, 1); finish(0);
    issue(PG, 32'h41, 1); finish(0);

    // hung driver: ISSUE plus TO+1 WAIT cycles of enable, then abort
    hang = 1'b1;
    issue(RD, 32'h20, 1);
    rd_q.delete();
    exp_err = 1'b1; exp_ea = AW'(32'h20);
    finish(0);
    chk("timeout_run", last_run, TO + 2);

    // reset mid-access, with a word still left in the FIFO
    push_word(16'h0077); push_word(16'h0088);
    issue(PG, 32'h50, 1);
    repeat (5) @(negedge clk);
    chk("mid_wait_en", wr_en, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_en", {rd_en, er_en, wr_en}, 0);
    chk("mrst_state", {busy, done, err, rd_valid}, 0);
    chk("mrst_drv", {drv_addr, drv_wdata}, 0);
    chk("mrst_ready", cmd_ready, 1);
    rst = 1'b1; hang = 1'b0;
    fifo_m.delete(); acc_q.delete();
    push_word(16'h0099);
    issue(PG, 32'h60, 1); finish(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
